// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: receives start + DATA_W data bits (MSB first) + parity bit, checks parity and
// presents the word on a valid/ready output. Optional inactivity abort: PARITY_FRAME_TIMEOUT_EN.
module parity_frame_ctrl #(
    parameter int DATA_W      = 8,
    parameter bit PARITY_ODD  = 1'b0,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              frame_start,
    input  logic              bit_en,
    input  logic              serial_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overrun,
    output logic              timeout,
    output logic [15:0]       frame_cnt
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;
    logic              par_bit;
    logic              data_done;
    logic              frame_go;
    logic              shift_go;
    logic              par_go;
    logic              load_go;
    logic              drop_go;
    logic              abort_go;
    logic              err;

    assign data_done = (cnt == CNT_W'(DATA_W));
    assign err       = (^sr) ^ par_bit ^ PARITY_ODD;
    assign busy      = (state != IDLE);

    // NOTE: every signal gets its default before the case so no path can leave it unassigned (no latches).
    always_comb begin
        state_nxt = state;
        frame_go  = 1'b0;
        shift_go  = 1'b0;
        par_go    = 1'b0;
        load_go   = 1'b0;
        drop_go   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    frame_go  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (data_done) begin
                        par_go    = 1'b1;
                        state_nxt = CHECK;
                    end else begin
                        shift_go = 1'b1;
                    end
                end else if (abort_go) begin
                    state_nxt = IDLE;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
                if (!out_valid || out_ready) begin
                    load_go = 1'b1;
                end else begin
                    drop_go = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sr      <= '0;
            cnt     <= '0;
            par_bit <= 1'b0;
        end else begin
            if (frame_go) begin
                sr  <= '0;
                cnt <= '0;
            end else if (shift_go) begin
                sr  <= {sr[DATA_W-2:0], serial_in};
                cnt <= cnt + 1'b1;
            end
            if (par_go) begin
                par_bit <= serial_in;
            end
        end
    end

    // A load in the accept cycle keeps out_valid high with the new word (no bubble).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_data  <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            overrun <= drop_go;
            if (load_go) begin
                out_data  <= sr;
                out_err   <= err;
                out_valid <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PARITY_FRAME_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Abort after TIMEOUT_CYC consecutive SHIFT cycles without a strobe.
    assign abort_go = (state == SHIFT) && !bit_en && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= abort_go;
            if (state != SHIFT || bit_en) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    // Without the timeout option TIMEOUT_CYC has no effect; the compare is constant false.
    assign abort_go = (TIMEOUT_CYC < 0);
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// tb_parity_frame_ctrl: random and directed frames; expected words are queued by the driver and
// checked cycle by cycle by an independent monitor that also drives out_ready.
`timescale 1ns/1ps
module tb_parity_frame_ctrl;
    localparam int DATA_W      = 8;
    localparam bit PARITY_ODD  = 1'b0;
    localparam int TIMEOUT_CYC = 16;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              frame_start = 1'b0;
    logic              bit_en = 1'b0;
    logic              serial_in = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic              out_valid;
    logic              busy;
    logic              overrun;
    logic              timeout;
    logic [15:0]       frame_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
        int                load_cyc;
    } frame_t;

    frame_t frames_q[$];
    int     ready_mode = 0;   // 0 random, 1 low, 2 high, 3 high only when a word loads
    bit     tmo_window = 1'b0;

    parity_frame_ctrl #(
        .DATA_W     (DATA_W),
        .PARITY_ODD (PARITY_ODD),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .frame_start(frame_start),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .out_data   (out_data),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overrun    (overrun),
        .timeout    (timeout),
        .frame_cnt  (frame_cnt)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Parity error: total number of ones over data and parity bit disagrees with the expected parity.
    function automatic logic exp_err(input logic [DATA_W-1:0] d, input logic p);
        int ones;
        ones = $countones(d) + int'(p);
        return (ones % 2) != int'(PARITY_ODD);
    endfunction

    // Monitor: compares outputs against the model each negedge, then predicts the next edge.
    initial begin : monitor
        logic [DATA_W-1:0] slot_data;
        logic              slot_err;
        bit                slot_valid;
        bit                exp_ovr;
        bit                load;
        bit                rdy;
        int                exp_cnt;
        frame_t            f;
        slot_data  = '0;
        slot_err   = 1'b0;
        slot_valid = 1'b0;
        exp_ovr    = 1'b0;
        exp_cnt    = 0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                slot_valid = 1'b0;
                exp_ovr    = 1'b0;
                exp_cnt    = 0;
                frames_q.delete();
                check("rst_valid", 32'(out_valid), 0);
                check("rst_data", 32'(out_data), 0);
                check("rst_err", 32'(out_err), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_overrun", 32'(overrun), 0);
                check("rst_timeout", 32'(timeout), 0);
                check("rst_frame_cnt", 32'(frame_cnt), 0);
                out_ready = 1'b0;
                continue;
            end
            check("out_valid", 32'(out_valid), 32'(slot_valid));
            if (slot_valid) begin
                check("out_data", 32'(out_data), 32'(slot_data));
                check("out_err", 32'(out_err), 32'(slot_err));
            end
            check("overrun", 32'(overrun), 32'(exp_ovr));
            check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt % 65536));
            if (!tmo_window) check("timeout_idle", 32'(timeout), 0);

            load = (frames_q.size() > 0) && (frames_q[0].load_cyc == cyc + 1);
            case (ready_mode)
                0:       rdy = 1'($urandom_range(0, 1));
                1:       rdy = 1'b0;
                2:       rdy = 1'b1;
                default: rdy = load;
            endcase
            out_ready = rdy;
            exp_ovr   = 1'b0;
            if (load) begin
                f = frames_q.pop_front();
                if (!slot_valid || rdy) begin
                    slot_data  = f.data;
                    slot_err   = f.err;
                    slot_valid = 1'b1;
                    exp_cnt++;
                end else begin
                    exp_ovr = 1'b1;
                end
            end else if (slot_valid && rdy) begin
                slot_valid = 1'b0;
            end
        end
    end

    task automatic send_frame(input logic [DATA_W-1:0] data, input logic par, input int max_gap);
        logic [DATA_W:0] bits;
        int              gap;
        bits = {data, par};
        @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        check("busy_shift", 32'(busy), 1);
        for (int i = DATA_W; i >= 0; i--) begin
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                serial_in   = 1'($urandom_range(0, 1));
                frame_start = ($urandom_range(0, 3) == 0);
                @(negedge clock);
            end
            frame_start = 1'b0;
            bit_en      = 1'b1;
            serial_in   = bits[i];
            if (i == 0) begin
                frames_q.push_back('{data: data, err: exp_err(data, par), load_cyc: cyc + 2});
            end
            @(negedge clock);
            bit_en = 1'b0;
        end
        // CHECK cycle: a start pulse here must be ignored.
        frame_start = 1'($urandom_range(0, 1));
        @(negedge clock);
        frame_start = 1'b0;
        check("busy_idle", 32'(busy), 0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clock);
        #1;
        resetn      = 1'b0;
        frame_start = 1'b0;
        bit_en      = 1'b0;
        repeat (cycles) @(negedge clock);
        #1;
        resetn = 1'b1;
    endtask

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int n;
        bit seen;
        repeat (3) @(negedge clock);
        #1;
        resetn = 1'b1;

        // T1: 0xA5 with even parity bit 0
        ready_mode = 2;
        send_frame(8'hA5, 1'b0, 0);
        check("t1_data", 32'(out_data), 32'hA5);
        check("t1_err", 32'(out_err), 0);
        check("t1_frame_cnt", 32'(frame_cnt), 1);

        // T2: wrong parity bit
        send_frame(8'hA5, 1'b1, 2);
        check("t2_err", 32'(out_err), 1);

        // T3: output held, second frame dropped
        do_reset(2);
        ready_mode = 1;
        send_frame(8'h3C, 1'b0, 1);
        send_frame(8'hC3, 1'b0, 1);
        check("t3_data", 32'(out_data), 32'h3C);
        check("t3_overrun", 32'(overrun), 1);
        check("t3_frame_cnt", 32'(frame_cnt), 1);
        ready_mode = 2;
        repeat (3) @(negedge clock);
        check("t3_drained", 32'(out_valid), 0);

        // T4: accept and load in the same cycle
        ready_mode = 3;
        send_frame(8'h3C, 1'b0, 0);
        send_frame(8'h0F, 1'b0, 0);
        check("t4_valid", 32'(out_valid), 1);
        check("t4_data", 32'(out_data), 32'h0F);
        check("t4_overrun", 32'(overrun), 0);
        ready_mode = 2;

        // T5: reset mid-frame, then a clean frame
        @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_en    = 1'b1;
            serial_in = 1'b1;
            @(negedge clock);
        end
        bit_en = 1'b0;
        do_reset(2);
        @(negedge clock);
        check("t5_busy", 32'(busy), 0);
        check("t5_frame_cnt", 32'(frame_cnt), 0);
        send_frame(8'hFF, 1'b0, 0);
        check("t5_data", 32'(out_data), 32'hFF);
        check("t5_err", 32'(out_err), 0);

        // Random frames with random gaps and random consumer backpressure
        ready_mode = 0;
        for (int k = 0; k < 60; k++) begin
            send_frame(DATA_W'($urandom()), 1'($urandom_range(0, 1)), 3);
        end

`ifdef PARITY_FRAME_TIMEOUT_EN
        // T6: strobes stop after 3 bits; a start pulse mid-frame must not restart anything
        ready_mode = 2;
        repeat (3) @(negedge clock);
        tmo_window = 1'b1;
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_en    = 1'b1;
            serial_in = 1'b1;
            @(negedge clock);
        end
        bit_en = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < TIMEOUT_CYC + 8) begin
            frame_start = (n == 2);
            @(negedge clock);
            n++;
            if (n == 3) check("t6_busy_held", 32'(busy), 1);
            if (timeout) seen = 1'b1;
        end
        frame_start = 1'b0;
        check("t6_timeout_seen", 32'(seen), 1);
        check("t6_timeout_cycle", 32'(n), 32'(TIMEOUT_CYC));
        check("t6_busy", 32'(busy), 0);
        @(negedge clock);
        check("t6_single_pulse", 32'(timeout), 0);
        tmo_window = 1'b0;
        send_frame(8'h5A, 1'b0, 1);
        check("t6_after_data", 32'(out_data), 32'h5A);
`endif

        // Drain the output and make sure every queued frame was consumed
        ready_mode = 2;
        n = 0;
        while (out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("final_drain", 32'(out_valid), 0);
        check("final_queue", 32'(frames_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
